// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor that processes CHUNK bits per clock,
// LSB chunk first, with the inter-chunk carry held in a register.
// CHUNK must divide WIDTH exactly; NCH = WIDTH/CHUNK cycles per operation.
module seq_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NCH  = WIDTH / CHUNK;
    localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_load;
    logic w_step;
    logic w_last;

    // Operands shift right one chunk per step so the active slice is always at the bottom
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK-1:0] w_slice;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_a_sl = r_a[CHUNK-1:0];
    assign w_b_sl = r_b[CHUNK-1:0];

    // One chunk of the carry chain
    assign {w_cout, w_slice} = (CHUNK+1)'(w_a_sl) + (CHUNK+1)'(w_b_sl) + (CHUNK+1)'(r_carry);

    // Carry into the slice MSB is a^b^s at that bit; overflow is that XOR the carry out
    assign w_ovf = w_a_sl[CHUNK-1] ^ w_b_sl[CHUNK-1] ^ w_slice[CHUNK-1] ^ w_cout;

    // Result slices enter at the top and move down, so after NCH steps the word is aligned
    assign w_acc_nxt = (r_acc >> CHUNK) | (WIDTH'(w_slice) << (WIDTH - CHUNK));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_idx == IDXW'(NCH - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, per-chunk accumulation and result/flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= w_last;
            if (w_load) begin
                r_a     <= a;
                r_b     <= mode ? ~b : b;
                r_carry <= mode ? 1'b1 : cin;
                r_idx   <= '0;
            end
            if (w_step) begin
                r_a     <= r_a >> CHUNK;
                r_b     <= r_b >> CHUNK;
                r_acc   <= w_acc_nxt;
                r_carry <= w_cout;
                r_idx   <= r_idx + IDXW'(1);
            end
            if (w_last) begin
                r_sum  <= w_acc_nxt;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
                r_zero <= (w_acc_nxt == '0);
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: directed and model-checked vectors for seq_addsub with
// CHUNK = 4, 16 and 1 (WIDTH = 16).
module tb_seq_addsub;

    localparam int unsigned W = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v = '0;
    logic        mode  = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic        cin   = 1'b0;

    logic [2:0]   busy_v;
    logic [2:0]   done_v;
    logic [2:0]   cout_v;
    logic [2:0]   ovf_v;
    logic [2:0]   zero_v;
    logic [W-1:0] sum_v [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode), .a(op_a), .b(op_b),
        .cin(cin), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]),
        .ovf(ovf_v[0]), .zero(zero_v[0])
    );

    seq_addsub #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode), .a(op_a), .b(op_b),
        .cin(cin), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]),
        .ovf(ovf_v[1]), .zero(zero_v[1])
    );

    seq_addsub #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode), .a(op_a), .b(op_b),
        .cin(cin), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]),
        .ovf(ovf_v[2]), .zero(zero_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {zero, ovf, cout, sum} as observed on instance w
    function automatic logic [18:0] obs(input int w);
        return {zero_v[w], ovf_v[w], cout_v[w], sum_v[w]};
    endfunction

    // Whole-word reference: {zero, ovf, cout, sum}
    function automatic logic [18:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mm, input logic mc);
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   r;
        logic         v;
        bb = mm ? ~mb : mb;
        ci = mm ? 1'b1 : mc;
        r  = {1'b0, ma} + {1'b0, bb} + 17'(ci);
        v  = (ma[W-1] == bb[W-1]) && (r[W-1] != ma[W-1]);
        return {(r[W-1:0] == '0), v, r[W], r[W-1:0]};
    endfunction

    task automatic issue(input int w, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tm, input logic tc);
        op_a       = ta;
        op_b       = tb_v;
        mode       = tm;
        cin        = tc;
        start_v[w] = 1'b1;
        tick();
        start_v[w] = 1'b0;
    endtask

    // Edges from now until done is seen; 64 means it never came
    task automatic wait_done(input int w, output int lat);
        lat = 0;
        while (lat < 64) begin
            tick();
            lat++;
            if (done_v[w]) break;
        end
    endtask

    initial begin
        int lat;
        int exp_lat;
        logic seen;
        logic [W-1:0] ra, rb;
        logic rm, rc;

        // Reset state
        tick();
        tick();
        check("rst.busy", 32'(busy_v[0]), 32'd0);
        check("rst.done", 32'(done_v[0]), 32'd0);
        check("rst.flags", 32'(obs(0)), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: add, no carry
        issue(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
        check("t1.busy", 32'(busy_v[0]), 32'd1);
        wait_done(0, lat);
        check("t1.lat", 32'(lat), 32'd4);
        check("t1.busy_done", 32'(busy_v[0]), 32'd0);
        check("t1.res", 32'(obs(0)), 32'({1'b0, 1'b0, 1'b0, 16'h5555}));

        // 2: carry to zero, then signed overflow via cin
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(0, lat);
        check("t2a.lat", 32'(lat), 32'd4);
        check("t2a.res", 32'(obs(0)), 32'({1'b1, 1'b0, 1'b1, 16'h0000}));
        issue(0, 16'h7FFF, 16'h0000, 1'b0, 1'b1);
        wait_done(0, lat);
        check("t2b.res", 32'(obs(0)), 32'({1'b0, 1'b1, 1'b0, 16'h8000}));

        // 3: subtract with borrow, then subtract with signed overflow (cin ignored)
        issue(0, 16'h0005, 16'h0007, 1'b1, 1'b0);
        wait_done(0, lat);
        check("t3a.res", 32'(obs(0)), 32'({1'b0, 1'b0, 1'b0, 16'hFFFE}));
        issue(0, 16'h8000, 16'h0001, 1'b1, 1'b1);
        wait_done(0, lat);
        check("t3b.res", 32'(obs(0)), 32'({1'b0, 1'b1, 1'b1, 16'h7FFF}));

        // 4a: start and new operands during RUN are ignored
        issue(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
        tick();
        tick();
        op_a       = 16'hFFFF;
        op_b       = 16'hFFFF;
        mode       = 1'b1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        check("t4a.sum_hold", 32'(sum_v[0]), 32'h7FFF);
        wait_done(0, lat);
        check("t4a.lat", 32'(lat), 32'd1);
        check("t4a.res", 32'(obs(0)), 32'({1'b0, 1'b0, 1'b0, 16'h5555}));
        // 4b: start in the done cycle is accepted with no gap
        issue(0, 16'h0F0F, 16'h0101, 1'b0, 1'b0);
        check("t4b.busy", 32'(busy_v[0]), 32'd1);
        check("t4b.done_clr", 32'(done_v[0]), 32'd0);
        wait_done(0, lat);
        check("t4b.lat", 32'(lat), 32'd4);
        check("t4b.res", 32'(obs(0)), 32'({1'b0, 1'b0, 1'b0, 16'h1010}));

        // 5: reset mid-op aborts without a done pulse
        issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5.busy", 32'(busy_v[0]), 32'd0);
        check("t5.res", 32'(obs(0)), 32'd0);
        seen = done_v[0];
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | done_v[0] | busy_v[0];
        end
        check("t5.no_done", 32'(seen), 32'd0);
        // reset wins over a simultaneous start
        rst_n      = 1'b0;
        start_v[0] = 1'b1;
        tick();
        rst_n      = 1'b1;
        start_v[0] = 1'b0;
        check("t5.rst_start", 32'(busy_v[0]), 32'd0);
        tick();
        check("t5.rst_start2", 32'(busy_v[0]), 32'd0);
        issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_done(0, lat);
        check("t5.lat", 32'(lat), 32'd4);
        check("t5.res", 32'(obs(0)), 32'({1'b0, 1'b0, 1'b0, 16'h3333}));

        // 6: single-cycle and bit-serial configurations
        issue(1, 16'hABCD, 16'h1111, 1'b0, 1'b0);
        check("t6.c16.done", 32'(done_v[1]), 32'd0);
        wait_done(1, lat);
        check("t6.c16.lat", 32'(lat), 32'd1);
        check("t6.c16.res", 32'(obs(1)), 32'({1'b0, 1'b0, 1'b0, 16'hBCDE}));
        issue(2, 16'hABCD, 16'h1111, 1'b0, 1'b0);
        wait_done(2, lat);
        check("t6.c1.lat", 32'(lat), 32'd16);
        check("t6.c1.res", 32'(obs(2)), 32'({1'b0, 1'b0, 1'b0, 16'hBCDE}));

        // 6: random add/sub per configuration against the word-level reference
        for (int w = 0; w < 3; w++) begin
            exp_lat = (w == 0) ? 4 : ((w == 1) ? 1 : 16);
            for (int k = 0; k < 200; k++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rm = 1'($urandom);
                rc = 1'($urandom);
                issue(w, ra, rb, rm, rc);
                wait_done(w, lat);
                check($sformatf("rnd.c%0d.%0d.lat", w, k), 32'(lat), 32'(exp_lat));
                check($sformatf("rnd.c%0d.%0d.res", w, k), 32'(obs(w)), 32'(model(ra, rb, rm, rc)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
Parametrised multi-cycle adder/subtractor. It processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first, with the carry held in a register between chunks. A start/busy/done handshake trades latency for a narrow carry chain. It is the sequential, wider successor to the 4-bit ripple adder and serves as the datapath add unit for the ALU and accumulator blocks.

Parameters:
WIDTH, 16, operand and result width in bits; WIDTH >= 1
CHUNK, 4, bits added per cycle; must divide WIDTH exactly. NCH = WIDTH/CHUNK cycles per operation.

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      synchronous active-low reset
start  input   1      request; sampled only when idle
mode   input   1      0 = add, 1 = subtract (a - b)
a      input   WIDTH  operand A, captured on accepted start
b      input   WIDTH  operand B, captured on accepted start
cin    input   1      carry-in for add; ignored when mode=1
busy   output  1      high while an operation is in progress
done   output  1      one-cycle pulse when results update
sum    output  WIDTH  result; held between operations
cout   output  1      add: carry-out. Sub: 1 = no borrow (a >= b unsigned)
ovf    output  1      two's-complement signed overflow
zero   output  1      1 when sum == 0

Behaviour:
- Clock and reset: single clock domain. rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: FSM = IDLE; busy = 0; done = 0; sum = 0; cout = 0; ovf = 0; zero = 0. All internal operand, carry, and chunk-index registers are cleared.
- States:
  - IDLE -> RUN on start=1. On that edge, capture a into the A register. Capture B as b when mode=0, or ~b when mode=1. Load the carry register with cin when mode=0, or 1 when mode=1. Clear the chunk index to 0.
  - RUN: each edge adds one CHUNK-bit slice (A slice + B slice + carry). The slice result is written into the sum working register and the carry register is updated. The index increments.
  - RUN -> IDLE on the edge that processes index NCH-1.
- Completion edge: sum, cout, ovf and zero are loaded from the working register and final carry, and done=1 for exactly one cycle.
- ovf is computed from the top chunk: carry into the MSB XOR carry out of the MSB.
- Outputs hold their values until the next completion edge. They do not change during RUN.
- busy = 1 in RUN, 0 in IDLE.
- Latency: start accepted at edge k gives done=1 after edge k+NCH. Throughput is one operation per NCH cycles.
- A start is accepted in the same cycle done is high, because the FSM is already in IDLE. Back-to-back operations therefore have no gap cycle.
- start while busy=1 is ignored, and captured operands are not disturbed. Changes on a, b, mode or cin during RUN have no effect.
- CHUNK = WIDTH gives NCH = 1: a single-cycle op with done one edge after start.
- CHUNK = 1 gives fully bit-serial operation.
- Wrap-around: sum is modulo 2^WIDTH. The carry out of the MSB goes only to cout.
- rst_n=0 during RUN aborts the operation on that edge. All outputs return to their reset values, and no done pulse is issued for the aborted op.
- Simultaneous rst_n=0 and start=1: reset wins.

Test Plan:
All cases use WIDTH=16, CHUNK=4 (NCH=4) unless stated.
1. Add, no carry: mode=0, a=0x1234, b=0x4321, cin=0, start one cycle -> busy=1 for 4 cycles; done pulses after edge 4; sum=0x5555, cout=0, ovf=0, zero=0.
2. Carry and zero: mode=0, a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, ovf=0. Then a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, ovf=1, cout=0.
3. Subtract: a=0x0005, b=0x0007, mode=1 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
4. Handshake and back-to-back:
   - Pulse start again during RUN with different operands -> ignored; first result is unchanged.
   - Assert start in the done cycle -> second op accepted; its done arrives exactly 4 cycles later.
5. Reset mid-op: start 0x1111+0x2222, drive rst_n=0 at RUN cycle 2 for one edge -> busy=0, sum=0, no done. A new op afterwards completes correctly.
6. Parameter sweep:
   - CHUNK=16: 0xABCD+0x1111 -> done one edge after start, sum=0xBCDE.
   - CHUNK=1: same op -> done after 16 edges, same result.
   - 200 random add/sub vectors per configuration are checked against a behavioural model.
